// File: rtl/front_line_buffer.sv
// Double-buffered sprite line buffer: the front layer writes opaque pixels into one bank
// while the mixer reads the other bank and clears each entry to transparent as it is read.
module front_line_buffer #(
   parameter int         SLICE_LEN = 16,
   parameter int         XW        = 9,
   parameter logic [2:0] TRANSP    = 3'b111
) (
   input  logic          clk,
   input  logic          RESETn,
   input  logic          wr_cen,
   input  logic          slice_ld,
   input  logic [7:0]    FD,
   input  logic [XW-1:0] FL_Y,
   input  logic          line_start,
   input  logic          rd_cen,
   input  logic [XW-1:0] rd_x,
   output logic [6:0]    pix_out,
   output logic          opaque,
   output logic          bank_sel,
   output logic          init_done,
   output logic          busy
);

   localparam int        DEPTH = 1 << XW;
   localparam int        CW    = $clog2(SLICE_LEN + 1);
   localparam logic [6:0] CLEAR = 7'h7F;

   typedef enum logic [1:0] {INIT, IDLE, WRITE} state_t;

   state_t          state, state_nxt;
   logic [XW-1:0]   clr_addr;
   logic [XW-1:0]   wr_addr;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            swap, start, step, wbank, wr_we, rd_en;
   logic [XW-1:0]   wr_ptr;
   logic [1:0]      mem_we;
   logic [XW-1:0]   mem_wa [2];
   logic [6:0]      mem_wd [2];
   logic [6:0]      rd_word_p0;
   logic            unused_fd7;

   logic [6:0] mem0 [DEPTH];
   logic [6:0] mem1 [DEPTH];

   assign unused_fd7 = FD[7];
   assign busy       = (state == WRITE);

   // A swap in the same cycle as slice_ld happens first, so that slice lands in the new write bank.
   always_comb begin
      swap    = (state != INIT) && line_start;
      start   = (state != INIT) && slice_ld;
      step    = (state == WRITE) && wr_cen && !swap && !start;
      wbank   = bank_sel ^ swap;
      wr_ptr  = start ? FL_Y : wr_addr;
      wr_we   = (start || step) && wr_cen && (FD[2:0] != TRANSP);
      rd_en   = (state != INIT) && rd_cen;
      cnt_nxt = start ? CW'(1) : cnt + CW'(1);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         INIT: if (clr_addr == '1) state_nxt = IDLE;
         default: begin
            if (start)
               state_nxt = (wr_cen && cnt_nxt == CW'(SLICE_LEN)) ? IDLE : WRITE;
            else if (swap)
               state_nxt = IDLE;
            else if (step && cnt_nxt == CW'(SLICE_LEN))
               state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!RESETn) state <= INIT;
      else         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!RESETn) begin
         clr_addr  <= '0;
         bank_sel  <= 1'b0;
         init_done <= 1'b0;
      end else begin
         if (state == INIT) clr_addr <= clr_addr + XW'(1);
         if (state == INIT && clr_addr == '1) init_done <= 1'b1;
         if (swap) bank_sel <= ~bank_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         wr_addr <= wr_cen ? FL_Y + XW'(1) : FL_Y;
         cnt     <= wr_cen ? CW'(1) : CW'(0);
      end else if (step) begin
         wr_addr <= wr_addr + XW'(1);
         cnt     <= cnt_nxt;
      end
   end

   // Each bank has one write port, owned by the writer or by the read-side clear.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         if (state == INIT) begin
            mem_we[b] = 1'b1;
            mem_wa[b] = clr_addr;
            mem_wd[b] = CLEAR;
         end else if (wbank == 1'(b)) begin
            mem_we[b] = wr_we;
            mem_wa[b] = wr_ptr;
            mem_wd[b] = FD[6:0];
         end else begin
            mem_we[b] = rd_en;
            mem_wa[b] = rd_x;
            mem_wd[b] = CLEAR;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we[0]) mem0[mem_wa[0]] <= mem_wd[0];
   end

   always_ff @(posedge clk) begin
      if (mem_we[1]) mem1[mem_wa[1]] <= mem_wd[1];
   end

   assign rd_word_p0 = wbank ? mem0[rd_x] : mem1[rd_x];

   // Read stage: result registered, held until the next rd_cen.
   always_ff @(posedge clk) begin
      if (!RESETn) begin
         pix_out <= '0;
         opaque  <= 1'b0;
      end else if (state == INIT) begin
         opaque  <= 1'b0;
      end else if (rd_en) begin
         pix_out <= rd_word_p0;
         opaque  <= (rd_word_p0[2:0] != TRANSP);
      end
   end

endmodule

// File: tb/tb_front_line_buffer.sv
// Scoreboard bench for front_line_buffer: directed slices, bank swaps and read-back of each line.
module tb_front_line_buffer;
   localparam int XW = 9;

   logic          clk = 1'b0;
   logic          RESETn = 1'b0;
   logic          wr_cen = 1'b0, slice_ld = 1'b0, line_start = 1'b0, rd_cen = 1'b0;
   logic [7:0]    FD = '0;
   logic [XW-1:0] FL_Y = '0, rd_x = '0;
   logic [6:0]    pix_out;
   logic          opaque, bank_sel, init_done, busy;

   int n_pass = 0;
   int n_total = 0;
   logic [7:0] exp_q [$];
   int         xq [$];
   logic       rd_d = 1'b0;

   always #5 clk = ~clk;

   front_line_buffer #(.SLICE_LEN(16), .XW(XW), .TRANSP(3'b111)) dut (
      .clk(clk), .RESETn(RESETn), .wr_cen(wr_cen), .slice_ld(slice_ld), .FD(FD),
      .FL_Y(FL_Y), .line_start(line_start), .rd_cen(rd_cen), .rd_x(rd_x),
      .pix_out(pix_out), .opaque(opaque), .bank_sel(bank_sel),
      .init_done(init_done), .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
   endtask

   // Monitor: one registered result per rd_cen, compared against the scoreboard.
   always @(posedge clk) rd_d <= rd_cen;

   always @(negedge clk) begin
      if (rd_d) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_read: got 'h%0h, expected no read", {opaque, pix_out});
         end else begin
            logic [7:0] e;
            int x;
            e = exp_q.pop_front();
            x = xq.pop_front();
            check($sformatf("read_x%0d", x), {24'h0, opaque, pix_out}, {24'h0, e});
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
      wr_cen = 1'b0; slice_ld = 1'b0; line_start = 1'b0; rd_cen = 1'b0;
   endtask

   task automatic pix(input logic [7:0] d);
      FD = d; wr_cen = 1'b1; step();
   endtask

   task automatic slice(input int y);
      FL_Y = XW'(y); slice_ld = 1'b1; step();
   endtask

   task automatic swap();
      line_start = 1'b1; step();
   endtask

   task automatic rd(input int x, input logic [6:0] p, input logic o);
      exp_q.push_back({o, p});
      xq.push_back(x);
      rd_x = XW'(x); rd_cen = 1'b1; step();
   endtask

   task automatic wait_init(input string name);
      int n;
      n = 0;
      while (!init_done && n < 600) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, n, 512);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_pix_out"},   pix_out,   0);
      check({tag, "_opaque"},    opaque,    0);
      check({tag, "_bank_sel"},  bank_sel,  0);
      check({tag, "_init_done"}, init_done, 0);
      check({tag, "_busy"},      busy,      0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_reset("rst");
      RESETn = 1'b1;
      wait_init("init_len");
      check("idle_busy", busy, 0);

      // Reads before any write
      rd(0, 7'h7F, 0);
      rd(300, 7'h7F, 0);

      // Basic slice at 100
      slice(100);
      check("busy_in_slice", busy, 1);
      repeat (16) pix(8'h2D);
      check("busy_after_slice", busy, 0);
      swap();
      check("bank_sel_swap", bank_sel, 1);
      for (int x = 99; x <= 117; x++)
         rd(x, (x >= 100 && x <= 115) ? 7'h2D : 7'h7F, (x >= 100 && x <= 115));
      rd(100, 7'h7F, 0);

      // Overlap: transparent never overwrites, opaque does; FD[7] ignored
      slice(0);
      repeat (16) pix(8'h09);
      slice(0);
      for (int i = 0; i < 16; i++) pix((i % 2) ? 8'h1F : 8'h92);
      swap();
      for (int x = 0; x < 16; x++) rd(x, (x % 2) ? 7'h09 : 7'h12, 1);
      rd(16, 7'h7F, 0);

      // X wrap
      slice(505);
      repeat (16) pix(8'h33);
      swap();
      rd(504, 7'h7F, 0);
      for (int i = 0; i < 16; i++) rd((505 + i) % 512, 7'h33, 1);
      rd(9, 7'h7F, 0);

      // Abort by line_start after 8 pixels; stray wr_cen afterwards writes nothing
      slice(200);
      repeat (8) pix(8'h21);
      swap();
      repeat (4) pix(8'h21);
      for (int x = 199; x <= 216; x++)
         rd(x, (x >= 200 && x <= 207) ? 7'h21 : 7'h7F, (x >= 200 && x <= 207));

      // slice_ld + line_start + wr_cen together: swap first, first pixel at FL_Y
      FL_Y = 9'd40; slice_ld = 1'b1; line_start = 1'b1; FD = 8'h44; wr_cen = 1'b1;
      step();
      repeat (15) pix(8'h44);
      rd(40, 7'h7F, 0);
      rd(55, 7'h7F, 0);
      for (int x = 208; x <= 211; x++) rd(x, 7'h7F, 0);
      swap();
      for (int x = 39; x <= 56; x++)
         rd(x, (x >= 40 && x <= 55) ? 7'h44 : 7'h7F, (x >= 40 && x <= 55));

      // Restart mid-slice, then the 16-pixel limit
      slice(300);
      repeat (4) pix(8'h2D);
      FL_Y = 9'd350; slice_ld = 1'b1; FD = 8'h2A; wr_cen = 1'b1;
      step();
      repeat (15) pix(8'h2A);
      check("busy_after_restart", busy, 0);
      pix(8'h2A);
      swap();
      rd(299, 7'h7F, 0);
      for (int x = 300; x <= 303; x++) rd(x, 7'h2D, 1);
      rd(304, 7'h7F, 0);
      rd(349, 7'h7F, 0);
      for (int x = 350; x <= 365; x++) rd(x, 7'h2A, 1);
      rd(366, 7'h7F, 0);

      // Reset mid-slice re-clears the buffer
      slice(10);
      repeat (5) pix(8'h2D);
      RESETn = 1'b0;
      step();
      step();
      check_reset("midrst");
      RESETn = 1'b1;
      wait_init("init_len2");
      rd(10, 7'h7F, 0);
      rd(14, 7'h7F, 0);

      step();
      step();
      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
